// File: rtl/fifo_rd_stream.sv
// Read-side controller of the dual-clock FIFO: owns the binary/Gray read pointers and the
// registered empty flag, and turns memory reads into a valid/ready stream through a 2-entry buffer.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE-1:0] raddr,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [ASIZE:0]   r_bin;
    logic [ASIZE:0]   r_ptr;
    logic             r_empty;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    logic [1:0]       r_cnt;

    logic             w_pop;
    logic             w_consume;
    logic [ASIZE:0]   w_bin_next;
    logic [ASIZE:0]   w_gray_next;

    // Stream handshake: a word transfers on any rclk edge where m_valid and m_ready are both
    // high; m_data/m_valid stay stable while m_valid=1 and m_ready=0.
    assign w_pop       = !r_empty && (r_cnt < 2'd2);
    assign w_consume   = (r_cnt != 2'd0) && m_ready;
    assign w_bin_next  = r_bin + (ASIZE+1)'(w_pop);
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_bin   <= '0;
            r_ptr   <= '0;
            r_empty <= 1'b1;
        end else begin
            r_bin   <= w_bin_next;
            r_ptr   <= w_gray_next;
            // Compared against the next pointer so the flag is registered yet never late.
            r_empty <= (w_gray_next == rq2_wptr);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_pop) begin
                        r_head <= mem_rdata;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_pop && !w_consume) begin
                        r_tail <= mem_rdata;
                        r_cnt  <= 2'd2;
                    end else if (w_pop && w_consume) begin
                        r_head <= mem_rdata;
                    end else if (w_consume) begin
                        r_cnt  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_consume) begin
                        r_head <= r_tail;
                        r_cnt  <= 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign raddr   = r_bin[ASIZE-1:0];
    assign rptr    = r_ptr;
    assign rempty  = r_empty;
    assign m_data  = r_head;
    assign m_valid = (r_cnt != 2'd0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a write-side model fills a memory array and pushes each word into
// an expected queue; a negedge monitor pops and compares every accepted stream word.
module tb_fifo_rd_stream;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;

    logic             rclk = 1'b0;
    logic             rrst;
    logic [ASIZE:0]   rq2_wptr;
    logic [ASIZE-1:0] raddr;
    logic [DSIZE-1:0] mem_rdata;
    logic [ASIZE:0]   rptr;
    logic             rempty;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] exp_q[$];
    logic [ASIZE:0]   wbin;
    logic             w_done;
    int               n_vec = 0;
    int               n_err = 0;

    fifo_rd_stream #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rq2_wptr  (rq2_wptr),
        .raddr     (raddr),
        .mem_rdata (mem_rdata),
        .rptr      (rptr),
        .rempty    (rempty),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 rclk = ~rclk;

    assign mem_rdata = mem[raddr];

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [DSIZE-1:0] v);
        mem[wbin[ASIZE-1:0]] = v;
        exp_q.push_back(v);
        wbin     = wbin + 1'b1;
        rq2_wptr = bin2gray(wbin);
    endtask

    task automatic wait_space();
        int b;
        logic [ASIZE:0] used;
        b = 0;
        used = wbin - gray2bin(rptr);
        while (used >= DEPTH[ASIZE:0] && b < 100) begin
            step();
            b++;
            used = wbin - gray2bin(rptr);
        end
        if (b >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL space_timeout: got %0d used, expected below %0d", used, DEPTH);
        end
    endtask

    task automatic drain(input int lim);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < lim) begin
            step();
            b++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d words left, expected 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rempty"}, rempty, 1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_rptr"}, rptr, 0);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_m_data"}, m_data, 0);
    endtask

    // Monitor: scoreboard pops, output stability under backpressure, single-bit Gray steps.
    logic             hold_prev = 1'b0;
    logic [DSIZE-1:0] data_prev;
    logic [ASIZE:0]   rptr_prev;
    logic             rst_prev = 1'b1;

    always @(negedge rclk) begin
        if (!rrst) begin
            if (hold_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, data_prev);
            end
            if (!rst_prev && rptr !== rptr_prev)
                check("rptr_one_bit", $countones(rptr ^ rptr_prev), 1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", m_data);
                end else begin
                    check("stream_data", m_data, exp_q.pop_front());
                end
            end
        end
        hold_prev <= !rrst && m_valid && !m_ready;
        data_prev <= m_data;
        rptr_prev <= rptr;
        rst_prev  <= rrst;
    end

    initial begin
        logic [ASIZE:0] start;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rrst     = 1'b1;
        rq2_wptr = 5;
        m_ready  = 1'b0;
        wbin     = '0;
        w_done   = 1'b0;

        // Reset held two cycles with a non-zero write pointer.
        step();
        step();
        check_reset_outputs("t1");

        // Single word with its exact latency.
        rrst     = 1'b0;
        rq2_wptr = 0;
        m_ready  = 1'b1;
        step();
        write_word(8'hA5);
        check("t2_empty_T", rempty, 1);
        step();
        check("t2_empty_T1", rempty, 0);
        check("t2_valid_T1", m_valid, 0);
        step();
        check("t2_valid_T2", m_valid, 1);
        check("t2_data_T2", m_data, 8'hA5);
        check("t2_rptr_T2", rptr, 1);
        check("t2_empty_T2", rempty, 1);
        step();
        check("t2_valid_T3", m_valid, 0);

        // Backpressure: buffer fills to two words, then drains back-to-back.
        rrst = 1'b1;
        step();
        rrst     = 1'b0;
        wbin     = '0;
        rq2_wptr = 0;
        m_ready  = 1'b0;
        exp_q.delete();
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        repeat (6) step();
        check("t3_rptr", rptr, 3);
        check("t3_empty", rempty, 0);
        check("t3_valid", m_valid, 1);
        check("t3_data", m_data, 8'h11);
        m_ready = 1'b1;
        step();
        check("t3_valid_2nd", m_valid, 1);
        check("t3_data_2nd", m_data, 8'h22);
        step();
        check("t3_valid_3rd", m_valid, 1);
        check("t3_data_3rd", m_data, 8'h33);
        step();
        check("t3_valid_end", m_valid, 0);
        check("t3_empty_end", rempty, 1);

        // Wrap-around: 40 words carry the read pointer past 31 back to 0.
        for (int i = 0; i < 40; i++) begin
            wait_space();
            write_word(8'(i));
            step();
        end
        drain(200);
        check("t4_rptr_final", rptr, bin2gray(wbin));
        check("t4_empty_final", rempty, 1);

        // Random backpressure and bursty writes.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    wait_space();
                    write_word(8'($urandom_range(0, 255)));
                    step();
                end
                w_done = 1'b1;
            end
            begin
                int c;
                c = 0;
                while (!(w_done && exp_q.size() == 0) && c < 5000) begin
                    m_ready = 1'($urandom_range(0, 1));
                    step();
                    c++;
                end
            end
        join
        m_ready = 1'b1;
        drain(100);
        check("t5_rptr_final", rptr, bin2gray(wbin));

        // Reset mid-stream with two words buffered and more pending.
        m_ready = 1'b0;
        start   = wbin;
        for (int i = 0; i < 5; i++) write_word(8'(8'hC0 + i));
        repeat (6) step();
        check("t6_empty_pre", rempty, 0);
        check("t6_valid_pre", m_valid, 1);
        check("t6_rptr_pre", rptr, bin2gray(start + 2'd2));
        rrst = 1'b1;
        step();
        check_reset_outputs("t6");
        rrst     = 1'b0;
        wbin     = '0;
        rq2_wptr = 0;
        m_ready  = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_stale", m_valid, 0);
        end
        write_word(8'h5A);
        write_word(8'h6B);
        write_word(8'h7C);
        drain(50);
        check("t6_rptr_final", rptr, bin2gray(wbin));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
